// File: rtl/uart_pkt_pkg.sv
// Shared types for the UART packet controller: FSM states, error causes and the
// default frame start marker.
package uart_pkt_pkg;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_CSUM,
    ERR_TIMEOUT,
    ERR_OVERRUN
  } err_cause_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_packet_ctrl_if.sv
// Byte-in / packet-out bundle between the UART receiver, the packet controller
// and the display logic. master = stimulus/consumer side, slave = controller.
interface uart_packet_ctrl_if #(
  parameter int NBYTES = 5
);
  logic [7:0]          rx_data;
  logic                rx_done;
  logic [8*NBYTES-1:0] pkt_data;
  logic                pkt_valid;
  logic                pkt_ready;
  logic                frame_err;
  logic                busy;

  modport master (
    output rx_data, rx_done, pkt_ready,
    input  pkt_data, pkt_valid, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_done, pkt_ready,
    output pkt_data, pkt_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts while enabled, restarts on every byte strobe and
// raises expire for one cycle when the gap reaches TIMEOUT_CYC-1 cycles.
module uart_byte_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] timer;

  assign expire = en && !clr && (timer == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || !en || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/uart_packet_ctrl.sv
// Sync-hunting frame controller: collects NBYTES payload bytes, checks an XOR
// checksum and presents packets on a valid/ready port. Optional UART_PKT_STATS_EN.
module uart_packet_ctrl
  import uart_pkt_pkg::*;
#(
  parameter int         NBYTES      = 5,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input logic               clk50,
  input logic               rst,
  uart_packet_ctrl_if.slave bus
`ifdef UART_PKT_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       err_csum_cnt,
  output logic [15:0]       err_timeout_cnt,
  output logic [15:0]       err_overrun_cnt
`endif
);
  localparam int PW = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t     state, state_nxt;
  err_cause_t err_cause;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    csum;
  logic [PW-1:0] shift_reg;
  logic [PW+7:0] shift_ext;
  logic          start, shift_en, load_pkt, expire;

  assign bus.busy  = (state != HUNT);
  assign shift_ext = {shift_reg, bus.rx_data};

  uart_byte_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk50),
    .rst   (rst),
    .clr   (bus.rx_done),
    .en    (bus.busy),
    .expire(expire)
  );

  always_ff @(posedge clk50) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_cause = ERR_NONE;
    start     = 1'b0;
    shift_en  = 1'b0;
    load_pkt  = 1'b0;
    case (state)
      HUNT: begin
        if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
          start     = 1'b1;
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (expire) begin
          err_cause = ERR_TIMEOUT;
          state_nxt = HUNT;
        end else if (bus.rx_done) begin
          shift_en = 1'b1;
          if (byte_cnt == CW'(NBYTES - 1)) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (expire) begin
          err_cause = ERR_TIMEOUT;
          state_nxt = HUNT;
        end else if (bus.rx_done) begin
          state_nxt = HUNT;
          // An old packet still waiting and not taken this cycle wins over the new one.
          if (bus.rx_data != csum) begin
            err_cause = ERR_CSUM;
          end else if (bus.pkt_valid && !bus.pkt_ready) begin
            err_cause = ERR_OVERRUN;
          end else begin
            load_pkt = 1'b1;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (shift_en) shift_reg <= shift_ext[PW-1:0];
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      byte_cnt      <= '0;
      csum          <= '0;
      bus.pkt_data  <= '0;
      bus.pkt_valid <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      if (start) begin
        byte_cnt <= '0;
        csum     <= '0;
      end else if (shift_en) begin
        byte_cnt <= byte_cnt + 1'b1;
        csum     <= csum ^ bus.rx_data;
      end
      if (load_pkt) begin
        bus.pkt_data  <= shift_reg;
        bus.pkt_valid <= 1'b1;
      end else if (bus.pkt_valid && bus.pkt_ready) begin
        bus.pkt_valid <= 1'b0;
      end
      bus.frame_err <= (err_cause != ERR_NONE);
    end
  end

`ifdef UART_PKT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk50) begin
    if (rst || stats_clr) begin
      err_csum_cnt    <= '0;
      err_timeout_cnt <= '0;
      err_overrun_cnt <= '0;
    end else begin
      case (err_cause)
        ERR_CSUM:    err_csum_cnt    <= sat_inc(err_csum_cnt);
        ERR_TIMEOUT: err_timeout_cnt <= sat_inc(err_timeout_cnt);
        ERR_OVERRUN: err_overrun_cnt <= sat_inc(err_overrun_cnt);
        default: ;
      endcase
    end
  end
`endif

endmodule
